// File: rtl/ball_motion_pkg.sv
// Shared types for the ball/sprite path: screen geometry and the sprite payload,
// plus the ball FSM state and the per-axis velocity.
package vga_pkg;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int X_POS_W  = 10;
    localparam int Y_POS_W  = 9;
endpackage

package sprite_pkg;
    import vga_pkg::*;

    // Bounding box; the display stage shows pixels strictly between the edges.
    typedef struct packed {
        logic [X_POS_W-1:0] left;
        logic [Y_POS_W-1:0] top;
        logic [X_POS_W-1:0] right;
        logic [Y_POS_W-1:0] bottom;
    } sprite_t;

    typedef enum logic [1:0] {SERVE, MOVE, HOLD} ball_state_e;

    localparam int MAG_W = 4;

    // dir: 0 = toward increasing coordinate, 1 = toward decreasing coordinate
    typedef struct packed {
        logic             dir;
        logic [MAG_W-1:0] mag;
    } vel_t;
endpackage

// File: rtl/ball_motion_if.sv
// Sprite hand-off between the ball motion writer and the sprite display reader.
interface sprite_if;
    import sprite_pkg::*;

    sprite_t sprite;

    modport motion_mp  (output sprite);
    modport display_mp (input  sprite);
endinterface

// File: rtl/ball_motion_axis_step.sv
// One axis of ball motion: next position with clamping at 0 / LIMIT, plus flags
// telling whether the step would have crossed the low or high edge.
module axis_step
    import sprite_pkg::*;
#(
    parameter int W     = 10,
    parameter int LIMIT = 632
) (
    input  logic [W-1:0] pos_i,
    input  vel_t         vel_i,
    output logic [W-1:0] pos_o,
    output logic         lo_hit_o,
    output logic         hi_hit_o
);
    logic [W:0] ext;
    logic [W:0] mag;

    // Compare in W+1 bits so neither the subtraction nor the addition can wrap.
    always_comb begin
        ext      = {1'b0, pos_i};
        mag      = (W+1)'(vel_i.mag);
        lo_hit_o = vel_i.dir && (ext < mag);
        hi_hit_o = !vel_i.dir && ((ext + mag) > (W+1)'(LIMIT));
        pos_o    = vel_i.dir ? pos_i - W'(vel_i.mag) : pos_i + W'(vel_i.mag);
        if (lo_hit_o)
            pos_o = '0;
        else if (hi_hit_o)
            pos_o = W'(LIMIT);
    end
endmodule

// File: rtl/ball_motion.sv
// Ball sprite writer: moves the ball once per frame, bounces off top/bottom,
// reverses on paddle hits and reports goals. Optional BALL_SPEEDUP_EN makes each
// paddle hit add 1 to |vx|, saturating at SPEED_MAX.
module ball_motion
    import vga_pkg::*;
    import sprite_pkg::*;
#(
    parameter int BALL_SIZE         = 8,
    parameter int SPEED_INIT        = 2,
    parameter int SPEED_MAX         = 6,
    parameter int SCORE_HOLD_FRAMES = 60
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        frame_tick_i,
    input  logic        serve_i,
    input  logic        collision_i,
    output logic        score_l_o,
    output logic        score_r_o,
    sprite_if.motion_mp sprite_o
);
    localparam int X_LIM  = SCREEN_W - BALL_SIZE;
    localparam int Y_LIM  = SCREEN_H - BALL_SIZE;
    localparam int X_CTR  = X_LIM / 2;
    localparam int Y_CTR  = Y_LIM / 2;
    localparam int HOLD_W = (SCORE_HOLD_FRAMES > 1) ? $clog2(SCORE_HOLD_FRAMES) : 1;
`ifdef BALL_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif
    localparam vel_t VEL_INIT = '{dir: 1'b0, mag: MAG_W'(SPEED_INIT)};

    ball_state_e        state_q, state_d;
    logic [X_POS_W-1:0] x_q, x_d, x_step, right_w;
    logic [Y_POS_W-1:0] y_q, y_d, y_step, bottom_w;
    vel_t               vx_q, vx_d, vx_eff, vy_q, vy_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               hit_q, hit_d, score_l_d, score_r_d, do_step;
    logic               x_lo, x_hi, y_lo, y_hi;

    // Paddle reversal (and optional speed-up) is applied before this frame's X step.
    always_comb begin
        vx_eff = vx_q;
        if (hit_q && state_q == MOVE) begin
            vx_eff.dir = ~vx_q.dir;
            if (SPEEDUP && (vx_q.mag < MAG_W'(SPEED_MAX)))
                vx_eff.mag = vx_q.mag + 1'b1;
        end
    end

    axis_step #(.W(X_POS_W), .LIMIT(X_LIM)) u_x_step (
        .pos_i(x_q), .vel_i(vx_eff), .pos_o(x_step), .lo_hit_o(x_lo), .hi_hit_o(x_hi)
    );

    axis_step #(.W(Y_POS_W), .LIMIT(Y_LIM)) u_y_step (
        .pos_i(y_q), .vel_i(vy_q), .pos_o(y_step), .lo_hit_o(y_lo), .hi_hit_o(y_hi)
    );

    // Next-state: FSM transitions plus per-frame motion, goal and bounce handling.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        vx_d      = vx_q;
        vy_d      = vy_q;
        hold_d    = hold_q;
        score_l_d = 1'b0;
        score_r_d = 1'b0;
        do_step   = 1'b0;
        hit_d     = frame_tick_i ? 1'b0 : (hit_q | (collision_i && state_q == MOVE));
        if (frame_tick_i) begin
            case (state_q)
                SERVE: if (serve_i) begin
                    state_d = MOVE;
                    do_step = 1'b1;
                end
                MOVE: do_step = 1'b1;
                HOLD: begin
                    if (hold_q == HOLD_W'(SCORE_HOLD_FRAMES - 1)) begin
                        state_d = SERVE;
                        hold_d  = '0;
                    end else begin
                        hold_d  = hold_q + 1'b1;
                    end
                end
                default: state_d = SERVE;
            endcase
        end
        if (do_step) begin
            vx_d = vx_eff;
            if (x_lo || x_hi) begin
                // Goal: recentre and serve toward the player who just conceded.
                state_d    = HOLD;
                hold_d     = '0;
                x_d        = X_POS_W'(X_CTR);
                y_d        = Y_POS_W'(Y_CTR);
                vx_d.dir   = x_lo;
                vx_d.mag   = MAG_W'(SPEED_INIT);
                vy_d.mag   = MAG_W'(SPEED_INIT);
                score_r_d  = x_lo;
                score_l_d  = x_hi;
            end else begin
                x_d = x_step;
                y_d = y_step;
                if (y_lo)
                    vy_d.dir = 1'b0;
                else if (y_hi)
                    vy_d.dir = 1'b1;
            end
        end
    end

    // State register; everything returns to the centred serve position on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= SERVE;
            x_q       <= X_POS_W'(X_CTR);
            y_q       <= Y_POS_W'(Y_CTR);
            vx_q      <= VEL_INIT;
            vy_q      <= VEL_INIT;
            hold_q    <= '0;
            hit_q     <= 1'b0;
            score_l_o <= 1'b0;
            score_r_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
            hold_q    <= hold_d;
            hit_q     <= hit_d;
            score_l_o <= score_l_d;
            score_r_o <= score_r_d;
        end
    end

    // Sprite box; a zero-size box hides the ball while a goal is being shown.
    always_comb begin
        right_w  = x_q + X_POS_W'(BALL_SIZE + 1);
        bottom_w = y_q + Y_POS_W'(BALL_SIZE + 1);
        if (state_q == HOLD) begin
            right_w  = x_q;
            bottom_w = y_q;
        end
    end

    assign sprite_o.sprite = '{left: x_q, top: y_q, right: right_w, bottom: bottom_w};
endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: a behavioural model predicts the outputs for every
// clock, expectations are queued at drive time and popped after the edge.
module tb_ball_motion;
    logic clk_i        = 1'b0;
    logic rst_ni       = 1'b0;
    logic frame_tick_i = 1'b0;
    logic serve_i      = 1'b0;
    logic collision_i  = 1'b0;
    logic score_l_o, score_r_o;

    sprite_if sif ();

    ball_motion #(
        .BALL_SIZE(8), .SPEED_INIT(2), .SPEED_MAX(6), .SCORE_HOLD_FRAMES(60)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .frame_tick_i(frame_tick_i),
        .serve_i(serve_i), .collision_i(collision_i),
        .score_l_o(score_l_o), .score_r_o(score_r_o), .sprite_o(sif)
    );

    always #5 clk_i = ~clk_i;

`ifdef BALL_SPEEDUP_EN
    localparam bit SPDUP = 1'b1;
`else
    localparam bit SPDUP = 1'b0;
`endif
    localparam int XL = 632, YL = 472, HOLDF = 60;

    typedef struct { int x; int y; int r; int b; int sl; int sr; } exp_t;
    exp_t q[$];

    int n_cmp = 0, n_mis = 0;
    // model: state 0=SERVE 1=MOVE 2=HOLD; v*d: 1 = decreasing coordinate
    int m_state, m_x, m_y, m_vxd, m_vxm, m_vyd, m_vym, m_hit, m_hold;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_x = 316; m_y = 236; m_vxd = 0; m_vxm = 2;
        m_vyd = 0; m_vym = 2; m_hit = 0; m_hold = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_left"},   sif.sprite.left,   316);
        chk({tag, "_top"},    sif.sprite.top,    236);
        chk({tag, "_right"},  sif.sprite.right,  325);
        chk({tag, "_bottom"}, sif.sprite.bottom, 245);
        chk({tag, "_sl"},     score_l_o,         0);
        chk({tag, "_sr"},     score_r_o,         0);
    endtask

    // One clock: drive inputs, predict post-edge outputs, compare after the edge.
    task automatic cycle(input bit tick, input bit serve, input bit coll);
        exp_t e;
        int nx, ny, nh;
        bit go;
        frame_tick_i = tick; serve_i = serve; collision_i = coll;
        e.sl = 0; e.sr = 0;
        nh = tick ? 0 : ((m_hit != 0 || (coll && m_state == 1)) ? 1 : 0);
        if (tick) begin
            go = 0;
            case (m_state)
                0: if (serve) begin m_state = 1; go = 1; end
                1: go = 1;
                default: if (m_hold == HOLDF - 1) begin m_state = 0; m_hold = 0; end
                         else m_hold++;
            endcase
            if (go) begin
                if (m_hit != 0) begin
                    m_vxd = 1 - m_vxd;
                    if (SPDUP && m_vxm < 6) m_vxm++;
                end
                nx = m_x + (m_vxd != 0 ? -m_vxm : m_vxm);
                if (nx < 0 || nx > XL) begin
                    e.sr = (nx < 0); e.sl = (nx > XL);
                    m_vxd = (nx < 0); m_vxm = 2; m_vym = 2;
                    m_x = 316; m_y = 236; m_hold = 0; m_state = 2;
                end else begin
                    m_x = nx;
                    ny = m_y + (m_vyd != 0 ? -m_vym : m_vym);
                    if (ny < 0) begin m_y = 0; m_vyd = 0; end
                    else if (ny > YL) begin m_y = YL; m_vyd = 1; end
                    else m_y = ny;
                end
            end
        end
        m_hit = nh;
        e.x = m_x; e.y = m_y;
        e.r = (m_state == 2) ? m_x : m_x + 9;
        e.b = (m_state == 2) ? m_y : m_y + 9;
        q.push_back(e);
        @(posedge clk_i); #1;
        e = q.pop_front();
        chk("left",   sif.sprite.left,   e.x);
        chk("top",    sif.sprite.top,    e.y);
        chk("right",  sif.sprite.right,  e.r);
        chk("bottom", sif.sprite.bottom, e.b);
        chk("score_l", score_l_o, e.sl);
        chk("score_r", score_r_o, e.sr);
        frame_tick_i = 1'b0; collision_i = 1'b0;
    endtask

    // Four clocks per frame; a paddle hit lands mid-frame, the tick is last.
    task automatic frame(input bit serve, input bit coll);
        cycle(0, serve, 0);
        cycle(0, serve, coll);
        cycle(0, serve, 0);
        cycle(1, serve, 0);
    endtask

    // Frames with optional automatic paddles near the left/right edges.
    task automatic run(input int n, input bit pad_l, input bit pad_r);
        bit c;
        for (int i = 0; i < n; i++) begin
            c = (m_state == 1) && ((pad_r && m_vxd == 0 && m_x >= 600) ||
                                   (pad_l && m_vxd == 1 && m_x <= 30));
            frame(0, c);
        end
    endtask

    initial begin
        model_reset();
        #12;
        chk_reset_vals("reset");
        #1 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // no serve: ball stays centred
        run(3, 0, 0);
        chk("idle_x", sif.sprite.left, 316);
        chk("idle_y", sif.sprite.top, 236);

        // serve launches and steps on the same tick
        frame(1, 0);
        chk("serve_x", sif.sprite.left, 318);
        chk("serve_y", sif.sprite.top, 238);

        // paddle hit reverses vx before the step
        frame(0, 1);
        chk("hit_x", sif.sprite.left, SPDUP ? 315 : 316);

        // long rally: bottom and top bounces, repeated paddle hits
        run(400, 1, 1);

        // no left paddle: ball exits left
        for (int i = 0; i < 400 && score_r_o !== 1'b1; i++) run(1, 0, 1);
        chk("goal_r_pulse", score_r_o, 1);
        chk("goal_r_hidden", sif.sprite.right, 316);
        run(59, 0, 0);
        chk("hold59_hidden", sif.sprite.right, 316);
        run(1, 0, 0);
        chk("hold_done_right", sif.sprite.right, 325);
        frame(1, 0);
        chk("reserve_x", sif.sprite.left, 314);

        // no right paddle: ball exits right
        for (int i = 0; i < 600 && score_l_o !== 1'b1; i++) run(1, 1, 0);
        chk("goal_l_pulse", score_l_o, 1);
        run(60, 0, 0);
        frame(1, 0);
        chk("reserve_l_x", sif.sprite.left, 318);
        run(20, 1, 1);

        // asynchronous reset in the middle of a rally
        #2 rst_ni = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        model_reset();
        q.delete();
        #3 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        run(2, 0, 0);
        chk("post_rst_x", sif.sprite.left, 316);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
